// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding and grant values.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  localparam int unsigned StarveW = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a starvation counter so fetch
// is forced through after MAX_STARVE consecutive losses.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_next,
  output logic load
);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               starved;

  assign starved    = (starve_q == StarveW'(MAX_STARVE));
  assign load       = arb_en & (if_req | dm_req);
  assign grant_next = (dm_req & ~(if_req & starved)) ? GRANT_DM : GRANT_IF;

  // Only a contested arbitration lost by fetch counts; DM cannot win once starved.
  always_comb begin
    starve_d = starve_q;
    if (load) begin
      if (grant_next == GRANT_IF) begin
        starve_d = '0;
      end else if (if_req) begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch and load/store through an
// IDLE -> ACCESS -> RESP sequence; data side has priority, fetch is protected from starvation.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_dm
);

  arb_state_e        state_q, state_d;
  logic              grant_q;
  logic              grant_next;
  logic              load;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              done;

  mem_arb_pick #(
    .MAX_STARVE(MAX_STARVE)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (state_q == StIdle),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .grant_next(grant_next),
    .load      (load)
  );

  assign done = (state_q == StAccess) & mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load) state_d = StAccess;
      StAccess: if (mem_ready) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= GRANT_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if (load) begin
        grant_q <= grant_next;
        if (grant_next == GRANT_DM) begin
          mem_we_q    <= dm_we;
          mem_addr_q  <= dm_addr;
          mem_wdata_q <= dm_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= if_addr;
          mem_wdata_q <= '0;
        end
      end
      // Stores complete without touching dm_rdata.
      if (done) begin
        if (grant_q == GRANT_IF) begin
          if_rdata_q <= mem_rdata;
        end else if (!mem_we_q) begin
          dm_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = (state_q == StResp) & (grant_q == GRANT_IF);
  assign dm_ack    = (state_q == StResp) & (grant_q == GRANT_DM);
  assign stall_if  = if_req & ~if_ack;
  assign stall_dm  = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences (starvation, mid-access reset) and random traffic.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, mem_ready, stall_if, stall_dm;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_STARVE(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_if (stall_if),
    .stall_dm (stall_dm)
  );

  typedef struct {
    logic rst; logic if_req; logic [31:0] if_addr;
    logic dm_req; logic dm_we; logic [31:0] dm_addr; logic [31:0] dm_wdata;
    logic ready; logic [31:0] rdata;
    logic e_en; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic e_if_ack; logic [31:0] e_if_rdata; logic e_dm_ack; logic [31:0] e_dm_rdata;
    logic e_st_if; logic e_st_dm;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random-traffic requester models
  logic        if_pend, dm_pend, dm_we_cur, prev_if_ack, prev_dm_ack, prev_en;
  logic [31:0] prev_addr;
  int          if_issued, dm_issued, if_acks, dm_acks;

  task automatic rand_cycle(input bit allow_new);
    if (prev_if_ack) if_pend = 1'b0;
    if (prev_dm_ack) dm_pend = 1'b0;
    if (allow_new && !if_pend && !prev_if_ack && $urandom_range(0, 3) == 0) begin
      if_pend = 1'b1;
      if_addr = $urandom() & 32'hFFFF_FFFC;
      if_issued++;
    end
    if (allow_new && !dm_pend && !prev_dm_ack && $urandom_range(0, 3) == 0) begin
      dm_pend   = 1'b1;
      dm_we_cur = 1'($urandom_range(0, 1));
      dm_addr   = $urandom() & 32'hFFFF_FFFC;
      dm_wdata  = $urandom();
      dm_issued++;
    end
    if_req    = if_pend;
    dm_req    = dm_pend;
    dm_we     = dm_we_cur;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = mem_addr ^ K;
    #1;
    chk("ack_exclusive", {31'd0, if_ack & dm_ack}, 32'd0);
    if (if_ack) begin
      if_acks++;
      chk("if_ack_pending", {31'd0, if_pend}, 32'd1);
      chk("rand_if_rdata", if_rdata, if_addr ^ K);
    end
    if (dm_ack) begin
      dm_acks++;
      chk("dm_ack_pending", {31'd0, dm_pend}, 32'd1);
      if (!dm_we_cur) chk("rand_dm_rdata", dm_rdata, dm_addr ^ K);
    end
    if (mem_en && mem_we) begin
      chk("rand_store_addr", mem_addr, dm_addr);
      chk("rand_store_wdata", mem_wdata, dm_wdata);
    end
    if (mem_en && prev_en) chk("addr_stable", mem_addr, prev_addr);
    chk("stall_if_eq", {31'd0, stall_if}, {31'd0, if_req & ~if_ack});
    chk("stall_dm_eq", {31'd0, stall_dm}, {31'd0, dm_req & ~dm_ack});
    prev_if_ack = if_ack;
    prev_dm_ack = dm_ack;
    prev_en     = mem_en;
    prev_addr   = mem_addr;
    @(posedge clk);
    #1;
  endtask

  logic exp_win [10];
  logic got_win;
  bit   seen;

  initial begin
    vec[0]  = '{1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0};
    vec[1]  = '{0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0};
    vec[2]  = '{0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2008000A,
                1, 0, 32'h40, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0};
    vec[3]  = '{0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 0, 32'h40, 32'h0, 1, 32'h2008000A, 0, 32'h0, 0, 0};
    vec[4]  = '{0, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,
                0, 0, 32'h40, 32'h0, 0, 32'h2008000A, 0, 32'h0, 0, 1};
    for (int i = 5; i < 9; i++) begin
      vec[i] = '{0, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, (i == 8), 32'h55,
                 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h2008000A, 0, 32'h0, 0, 1};
    end
    vec[9]  = '{0, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,
                0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h2008000A, 1, 32'h0, 0, 0};
    vec[10] = '{0, 0, 32'h0, 1, 0, 32'h104, 32'h0, 1, 32'h77,
                0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h2008000A, 0, 32'h0, 0, 1};
    vec[11] = '{0, 0, 32'h0, 1, 0, 32'h104, 32'h0, 1, 32'hCAFEF00D,
                1, 0, 32'h104, 32'h0, 0, 32'h2008000A, 0, 32'h0, 0, 1};
    vec[12] = '{0, 0, 32'h0, 1, 0, 32'h104, 32'h0, 1, 32'h99,
                0, 0, 32'h104, 32'h0, 0, 32'h2008000A, 1, 32'hCAFEF00D, 0, 0};
    vec[13] = '{0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h88,
                0, 0, 32'h104, 32'h0, 0, 32'h2008000A, 0, 32'hCAFEF00D, 0, 0};
    vec[14] = '{0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                0, 0, 32'h104, 32'h0, 0, 32'h2008000A, 0, 32'hCAFEF00D, 0, 0};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    step();
    step();

    // Directed table: each row is one clock cycle of inputs and expected outputs.
    for (int i = 0; i < 15; i++) begin
      rst = vec[i].rst; if_req = vec[i].if_req; if_addr = vec[i].if_addr;
      dm_req = vec[i].dm_req; dm_we = vec[i].dm_we; dm_addr = vec[i].dm_addr;
      dm_wdata = vec[i].dm_wdata; mem_ready = vec[i].ready; mem_rdata = vec[i].rdata;
      #1;
      chk($sformatf("r%0d mem_en", i), {31'd0, mem_en}, {31'd0, vec[i].e_en});
      chk($sformatf("r%0d mem_we", i), {31'd0, mem_we}, {31'd0, vec[i].e_we});
      chk($sformatf("r%0d mem_addr", i), mem_addr, vec[i].e_addr);
      chk($sformatf("r%0d mem_wdata", i), mem_wdata, vec[i].e_wdata);
      chk($sformatf("r%0d if_ack", i), {31'd0, if_ack}, {31'd0, vec[i].e_if_ack});
      chk($sformatf("r%0d if_rdata", i), if_rdata, vec[i].e_if_rdata);
      chk($sformatf("r%0d dm_ack", i), {31'd0, dm_ack}, {31'd0, vec[i].e_dm_ack});
      chk($sformatf("r%0d dm_rdata", i), dm_rdata, vec[i].e_dm_rdata);
      chk($sformatf("r%0d stall_if", i), {31'd0, stall_if}, {31'd0, vec[i].e_st_if});
      chk($sformatf("r%0d stall_dm", i), {31'd0, stall_dm}, {31'd0, vec[i].e_st_dm});
      step();
    end

    // Contested requests: DM wins four times, then fetch is forced through.
    for (int a = 0; a < 10; a++) exp_win[a] = (a % 5 == 4) ? GRANT_IF : GRANT_DM;
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    for (int a = 0; a < 10; a++) begin
      seen = 1'b0;
      got_win = GRANT_IF;
      for (int k = 0; k < 12 && !seen; k++) begin
        if (if_ack || dm_ack) begin
          seen = 1'b1;
          got_win = dm_ack ? GRANT_DM : GRANT_IF;
        end else begin
          step();
        end
      end
      chk($sformatf("starve_ack_seen%0d", a), {31'd0, seen}, 32'd1);
      chk($sformatf("starve_winner%0d", a), {31'd0, got_win}, {31'd0, exp_win[a]});
      if (a == 9) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      step();
    end
    step();

    // Reset during the second ACCESS cycle abandons the fetch.
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0;
    #1;
    chk("rst_seq idle mem_en", {31'd0, mem_en}, 32'd0);
    step();
    chk("rst_seq acc1 mem_en", {31'd0, mem_en}, 32'd1);
    chk("rst_seq acc1 addr", mem_addr, 32'h80);
    step();
    rst = 1'b1;
    #1;
    chk("rst_seq acc2 mem_en", {31'd0, mem_en}, 32'd1);
    step();
    rst = 1'b0; if_req = 1'b0; mem_ready = 1'b1;
    #1;
    chk("rst_seq after mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_seq after addr", mem_addr, 32'h0);
    chk("rst_seq after if_rdata", if_rdata, 32'h0);
    chk("rst_seq after dm_rdata", dm_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_seq no ack", {30'd0, if_ack, dm_ack}, 32'd0);
      step();
    end
    if_req = 1'b1; if_addr = 32'h84; mem_rdata = 32'h1234_5678;
    #1;
    chk("rst_seq fresh idle", {31'd0, mem_en}, 32'd0);
    step();
    chk("rst_seq fresh mem_en", {31'd0, mem_en}, 32'd1);
    chk("rst_seq fresh addr", mem_addr, 32'h84);
    step();
    chk("rst_seq fresh ack", {31'd0, if_ack}, 32'd1);
    chk("rst_seq fresh rdata", if_rdata, 32'h1234_5678);
    if_req = 1'b0;
    step();

    // Random traffic, then drain outstanding requests.
    if_pend = 1'b0; dm_pend = 1'b0; dm_we_cur = 1'b0;
    prev_if_ack = 1'b0; prev_dm_ack = 1'b0; prev_en = 1'b0; prev_addr = '0;
    if_issued = 0; dm_issued = 0; if_acks = 0; dm_acks = 0;
    for (int c = 0; c < 2000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 60; c++) rand_cycle(1'b0);
    chk("rand if acks", 32'(if_acks), 32'(if_issued));
    chk("rand dm acks", 32'(dm_acks), 32'(dm_issued));
    chk("rand drained", {30'd0, if_pend, dm_pend}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
